// File: rtl/fetch_unit.sv
// fetch_unit: dual-issue instruction fetch with 2-entry bundle queue and branch redirect.
// Optional halt-on-opcode feature enabled by defining FETCH_HALT_EN.
module fetch_unit #(
    parameter int unsigned ADDR_W   = 15,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              interlock,
    input  logic              branch_flag,
    input  logic [31:0]       branch_pc,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [63:0]       imem_dout,
    output logic [31:0]       pc,
    output logic [63:0]       inst,
    output logic              halted
);
    localparam logic [95:0] NOP_E = {32'h0, 64'hE000_0000_E000_0000};
    logic [31:0] fetch_pc_q, fetch_pc_d, infl_pc_q, infl_pc_d;
    logic        inflight_q, inflight_d, halted_q, halted_d;
    logic [1:0]  count_q, count_d, cnt_mid;
    logic [95:0] hd_q, hd_d, tl_q, tl_d, out_q, out_d, resp;
    logic        resp_valid, consume, pop, bypass, push;
    logic [2:0]  occ;
    // a redirect in the same cycle kills the response of the older request
    assign resp_valid = inflight_q & ~branch_flag;
    assign resp       = {infl_pc_q, imem_dout};
    assign consume    = ~interlock & ((count_q != 2'd0) | resp_valid);
    assign pop        = consume & (count_q != 2'd0);
    assign bypass     = consume & (count_q == 2'd0);
    assign push       = resp_valid & ~bypass;
    assign cnt_mid    = count_q - {1'b0, pop};
    assign occ        = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, consume};
    assign imem_en    = ~rst & (branch_flag | (~halted_q & (occ < 3'd2)));
    assign imem_addr  = branch_flag ? branch_pc[ADDR_W-1:0] : fetch_pc_q[ADDR_W-1:0];
    assign pc         = out_q[95:64];
    assign inst       = out_q[63:0];
    assign halted     = halted_q;
    always_comb begin
        fetch_pc_d = branch_flag ? branch_pc + 32'd1 : imem_en ? fetch_pc_q + 32'd1 : fetch_pc_q;
        infl_pc_d  = branch_flag ? branch_pc : fetch_pc_q;
        inflight_d = imem_en;
        hd_d       = (push && cnt_mid == 2'd0) ? resp : pop ? tl_q : hd_q;
        tl_d       = (push && cnt_mid == 2'd1) ? resp : tl_q;
        count_d    = branch_flag ? 2'd0 : cnt_mid + {1'b0, push};
        out_d      = branch_flag ? NOP_E : interlock ? out_q : pop ? hd_q : bypass ? resp : NOP_E;
    end
`ifdef FETCH_HALT_EN
    assign halted_d = ~branch_flag & (halted_q | (out_d[63:58] == 6'b111111));
`else
    assign halted_d = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            infl_pc_q  <= 32'h0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            hd_q       <= 96'h0;
            tl_q       <= 96'h0;
            out_q      <= NOP_E;
            halted_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            infl_pc_q  <= infl_pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            hd_q       <= hd_d;
            tl_q       <= tl_d;
            out_q      <= out_d;
            halted_q   <= halted_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit; directed vectors with hand-computed bundles.
module tb_fetch_unit;
    localparam logic [63:0] NOP = 64'hE000_0000_E000_0000;
    localparam logic [95:0] NP  = {32'h0, NOP};
    logic        clk = 0, rst = 1, interlock = 0, branch_flag = 0, halt_mode = 0;
    logic [31:0] branch_pc = 0, pc, pc2;
    logic        imem_en, imem_en2, halted, halted2;
    logic [14:0] imem_addr, imem_addr2;
    logic [63:0] imem_dout = 0, imem_dout2 = 0, inst, inst2;
    logic        rst_e, load_e;
    logic [95:0] last;
    logic [95:0] exp_q[$], exp2_q[$];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .interlock(interlock), .branch_flag(branch_flag), .branch_pc(branch_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_dout(imem_dout),
        .pc(pc), .inst(inst), .halted(halted)
    );
    fetch_unit #(.ADDR_W(15), .RESET_PC(32'h7FFF)) dut2 (
        .clk(clk), .rst(rst), .interlock(1'b0), .branch_flag(1'b0), .branch_pc(32'h0),
        .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_dout(imem_dout2),
        .pc(pc2), .inst(inst2), .halted(halted2)
    );

    // word k = {k, k}; in halt mode word 3 carries opcode 6'b111111 in its upper slot
    function automatic logic [63:0] mem(input logic [14:0] a, input logic hm);
        logic [31:0] k;
        k = {17'h0, a};
        return {(hm && a == 15'd3) ? (k | 32'hFC00_0000) : k, k};
    endfunction

    function automatic logic [95:0] w(input logic [31:0] k);
        return {k, k, k};
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_dout <= mem(imem_addr, halt_mode);
        if (imem_en2) imem_dout2 <= mem(imem_addr2, 1'b0);
        rst_e  <= rst;
        load_e <= ~interlock | branch_flag;
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_e || load_e) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_underflow got=%h exp=none", {pc, inst});
            end else check("out", {pc, inst}, exp_q.pop_front());
        end else check("hold", {pc, inst}, last);
        last = {pc, inst};
        if (!rst_e && exp2_q.size() != 0) check("out2", {pc2, inst2}, exp2_q.pop_front());
    end

    always @(negedge clk)
        if (!rst_e)
            assert (dut.count_q + dut.inflight_q <= 2)
            else begin
                total++;
                bad++;
                $display("FAIL occupancy got=%0d exp<=2", dut.count_q + dut.inflight_q);
            end

    task automatic cyc(input logic r, input logic il, input logic br, input logic [31:0] bp, input logic [95:0] e);
        rst = r;
        interlock = il;
        branch_flag = br;
        branch_pc = bp;
        if (r || !il || br) exp_q.push_back(e);
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp2_q.push_back(NP);
        exp2_q.push_back(w(32'h7FFF));
        exp2_q.push_back({32'h8000, 64'h0});
        cyc(1, 0, 0, 0, NP); check("en_rst", imem_en, 0); tick;
        cyc(1, 0, 0, 0, NP); check("en_rst", imem_en, 0); tick;
        cyc(0, 0, 0, 0, NP); check("first_req", {imem_en, imem_addr}, {1'b1, 15'h0});
        check("wrap_addr0", {imem_en2, imem_addr2}, {1'b1, 15'h7FFF}); tick;
        cyc(0, 0, 0, 0, w(0)); check("wrap_addr1", {imem_en2, imem_addr2}, {1'b1, 15'h0}); tick;
        for (int k = 1; k <= 4; k++) begin cyc(0, 0, 0, 0, w(k)); tick; end
        for (int i = 0; i < 5; i++) begin cyc(0, 1, 0, 0, NP); tick; end
        for (int k = 5; k <= 7; k++) begin cyc(0, 0, 0, 0, w(k)); tick; end
        for (int i = 0; i < 2; i++) begin cyc(0, 1, 0, 0, NP); tick; end
        cyc(0, 1, 1, 32'h100, NP); check("br_req", {imem_en, imem_addr}, {1'b1, 15'h100}); tick;
        for (int k = 32'h100; k <= 32'h102; k++) begin cyc(0, 0, 0, 0, w(k)); tick; end
        cyc(1, 0, 0, 0, NP); tick;
        cyc(0, 0, 0, 0, NP); tick;
        cyc(0, 0, 0, 0, w(0)); tick;
        cyc(0, 0, 0, 0, w(1)); tick;
`ifdef FETCH_HALT_EN
        halt_mode = 1;
        cyc(1, 0, 0, 0, NP); tick;
        cyc(0, 0, 0, 0, NP); tick;
        for (int k = 0; k <= 2; k++) begin cyc(0, 0, 0, 0, w(k)); tick; end
        cyc(0, 0, 0, 0, {32'h3, 32'hFC00_0003, 32'h3}); tick;
        check("halted_set", {halted, imem_en}, {1'b1, 1'b0});
        cyc(0, 0, 0, 0, w(4)); tick;
        cyc(0, 0, 0, 0, NP); tick;
        cyc(0, 0, 0, 0, NP); check("halt_noissue", imem_en, 0); tick;
        cyc(0, 0, 1, 0, NP); check("halt_br_req", {imem_en, imem_addr}, {1'b1, 15'h0}); tick;
        check("halted_clr", halted, 0);
        cyc(0, 0, 0, 0, w(0)); tick;
        cyc(0, 0, 0, 0, w(1)); tick;
`else
        check("halted_tied", {halted, halted2}, 0);
`endif
        @(negedge clk);
        #1;
        check("drain", exp_q.size() + exp2_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
